// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the MAR/MDR memory interface.
//
// A rising edge on Read or Write is accepted in IDLE. The address, write data
// and operation are latched, WAIT_CYCLES wait states follow, and the access
// then completes in a single DONE cycle on an internal word-addressed RAM.
// MemReady is a one-cycle completion pulse, so the control sequencer can hold
// MDRin until MemReady instead of relying on fixed T-state timing.
//
// Optional feature, selected by the macro MEM_WP_EN:
//   When it is defined, writes to addresses 0..WP_TOP still run the full
//   sequence and pulse MemReady, but they leave the RAM unmodified and pulse
//   WpFault. When it is undefined, WpFault is tied to 0.
//
// Ports:
//   clock    in   system clock; all state updates on the rising edge
//   clear    in   asynchronous active-low reset
//   Read     in   read strobe; a request is its rising edge
//   Write    in   write strobe; a request is its rising edge
//   Address  in   word address from MAR
//   DataIn   in   write data from MDR
//   Mdatain  out  read data; holds until the next completed read
//   MemReady out  one-cycle completion pulse for reads and writes
//   Busy     out  high from accept until completion
//   ReqError out  sticky flag for simultaneous Read and Write edges
//   WpFault  out  one-cycle pulse on a blocked write
module mem_responder #(
  parameter int ADDR_WIDTH  = 9,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_CYCLES = 1,
  parameter int WP_TOP      = 15
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  Read,
  input  logic                  Write,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0] DataIn,
  output logic [DATA_WIDTH-1:0] Mdatain,
  output logic                  MemReady,
  output logic                  Busy,
  output logic                  ReqError,
  output logic                  WpFault
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  // The counter is preloaded at accept, so it holds the remaining wait states minus one.
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic [ADDR_WIDTH-1:0] WP_LIMIT = ADDR_WIDTH'(WP_TOP);
`ifdef MEM_WP_EN
  localparam bit WP_ON = 1'b1;
`else
  localparam bit WP_ON = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                state_q;
  logic [3:0]            wait_cnt_q;
  logic                  rd_prev_q;
  logic                  wr_prev_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  op_wr_q;
  logic [DATA_WIDTH-1:0] mdata_q;
  logic                  ready_q;
  logic                  busy_q;
  logic                  req_err_q;
  logic                  wp_fault_q;

  logic [DATA_WIDTH-1:0] ram [DEPTH];

  logic rd_req;
  logic wr_req;
  logic wr_blocked;
  logic ram_we_d;

  always_comb begin
    rd_req     = Read & ~rd_prev_q;
    wr_req     = Write & ~wr_prev_q;
    wr_blocked = WP_ON && (addr_q <= WP_LIMIT);
    ram_we_d   = (state_q == S_DONE) && op_wr_q && !wr_blocked;
  end

  // The RAM is not reset. An aborted write cannot commit, because reset forces
  // the FSM out of DONE before the next clock edge.
  always_ff @(posedge clock) begin
    if (ram_we_d) begin
      ram[addr_q] <= data_q;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      rd_prev_q  <= 1'b0;
      wr_prev_q  <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      op_wr_q    <= 1'b0;
      mdata_q    <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      req_err_q  <= 1'b0;
      wp_fault_q <= 1'b0;
    end else begin
      // The strobe history is sampled in every state. An edge that arrives
      // while busy is therefore used up and cannot fire later.
      rd_prev_q  <= Read;
      wr_prev_q  <= Write;
      ready_q    <= 1'b0;
      wp_fault_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (rd_req && wr_req) begin
            req_err_q <= 1'b1;
          end else if (rd_req || wr_req) begin
            addr_q     <= Address;
            data_q     <= DataIn;
            op_wr_q    <= wr_req;
            busy_q     <= 1'b1;
            wait_cnt_q <= WAIT_INIT;
            state_q    <= (WAIT_CYCLES > 0) ? S_WAIT : S_DONE;
          end
        end
        S_WAIT: begin
          if (wait_cnt_q == '0) begin
            state_q <= S_DONE;
          end else begin
            wait_cnt_q <= wait_cnt_q - 4'd1;
          end
        end
        S_DONE: begin
          // These outputs are registered on the edge that leaves DONE. That
          // makes the latency WAIT_CYCLES+1 and aligns Mdatain with MemReady.
          if (!op_wr_q) begin
            mdata_q <= ram[addr_q];
          end
          wp_fault_q <= op_wr_q & wr_blocked;
          ready_q    <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Mdatain  = mdata_q;
  assign MemReady = ready_q;
  assign Busy     = busy_q;
  assign ReqError = req_err_q;
`ifdef MEM_WP_EN
  assign WpFault  = wp_fault_q;
`else
  assign WpFault  = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder with a decoupled scoreboard. Each stimulus that
// should complete pushes the expected response and its completion cycle. The
// monitor pops an entry on every MemReady and compares the response with it.
module tb_mem_responder;

  localparam int W = 1;

  logic        clock   = 1'b0;
  logic        clear   = 1'b0;
  logic        Read    = 1'b0;
  logic        Write   = 1'b0;
  logic [8:0]  Address = '0;
  logic [31:0] DataIn  = '0;
  logic [31:0] Mdatain;
  logic        MemReady;
  logic        Busy;
  logic        ReqError;
  logic        WpFault;

  mem_responder #(
    .ADDR_WIDTH (9),
    .DATA_WIDTH (32),
    .WAIT_CYCLES(W),
    .WP_TOP     (15)
  ) dut (
    .clock   (clock),
    .clear   (clear),
    .Read    (Read),
    .Write   (Write),
    .Address (Address),
    .DataIn  (DataIn),
    .Mdatain (Mdatain),
    .MemReady(MemReady),
    .Busy    (Busy),
    .ReqError(ReqError),
    .WpFault (WpFault)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int compared   = 0;
  int mismatched = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  typedef struct {
    bit          rd;
    logic [31:0] data;
    bit          wp;
    bit          exact;  // 0: read data must differ from data (value never written)
    int          due;
  } exp_t;

  exp_t        sb[$];
  exp_t        e_mon;
  logic [31:0] last_rd    = '0;
  bit          last_known = 1'b1;
  int          busy_run   = 0;

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clock) begin
    if (!clear) begin
      busy_run = 0;
    end else begin
      if (Busy) begin
        busy_run++;
      end else if (busy_run != 0) begin
        check("busy_length", busy_run, W + 1);
        busy_run = 0;
      end
      if (MemReady) begin
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_memready: got 1, expected 0 (cycle %0d)", cyc);
        end else begin
          e_mon = sb.pop_front();
          check("ready_cycle", cyc, e_mon.due);
          check("wpfault_done", {31'd0, WpFault}, {31'd0, e_mon.wp});
          check("busy_at_ready", {31'd0, Busy}, 32'd0);
          if (e_mon.rd) begin
            if (e_mon.exact) begin
              check("read_data", Mdatain, e_mon.data);
              last_rd    = e_mon.data;
              last_known = 1'b1;
            end else begin
              compared++;
              if (Mdatain === e_mon.data) begin
                mismatched++;
                $display("FAIL protected_readback: got %h, required anything but %h", Mdatain, e_mon.data);
              end
              last_known = 1'b0;
            end
          end else if (last_known) begin
            check("mdatain_hold_on_write", Mdatain, last_rd);
          end
        end
      end else begin
        check("wpfault_quiet", {31'd0, WpFault}, 32'd0);
      end
    end
  end

  task automatic push_exp(input bit rd, input logic [31:0] d, input bit wp, input bit exact);
    exp_t e;
    e.rd    = rd;
    e.data  = d;
    e.wp    = wp;
    e.exact = exact;
    e.due   = cyc + W + 2;  // accept on the next edge, then W+1 more cycles
    sb.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || Busy) && n < 40) begin
      @(negedge clock);
      n++;
    end
    compared++;
    if (n >= 40) begin
      mismatched++;
      $display("FAIL drain_timeout: %0d responses still pending after %0d cycles, expected 0", sb.size(), n);
      sb.delete();
    end
    @(negedge clock);
  endtask

  task automatic do_op(input bit rd, input bit wr, input logic [8:0] a, input logic [31:0] d,
                       input int hold, input bit exp_rsp, input logic [31:0] exp_d,
                       input bit exp_wp, input bit exact);
    @(negedge clock);
    Read    = rd;
    Write   = wr;
    Address = a;
    DataIn  = d;
    if (exp_rsp) push_exp(rd, exp_d, exp_wp, exact);
    @(negedge clock);
    Address = ~a;  // changes after accept must not reach the access in flight
    DataIn  = ~d;
    if (exp_rsp) check("busy_after_accept", {31'd0, Busy}, 32'd1);
    else         check("busy_no_accept", {31'd0, Busy}, 32'd0);
    repeat (hold - 1) @(negedge clock);
    Read  = 1'b0;
    Write = 1'b0;
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clock);
    check("reset_mdatain", Mdatain, 32'd0);
    check("reset_memready", {31'd0, MemReady}, 32'd0);
    check("reset_busy", {31'd0, Busy}, 32'd0);
    check("reset_reqerror", {31'd0, ReqError}, 32'd0);
    check("reset_wpfault", {31'd0, WpFault}, 32'd0);
    clear = 1'b1;
    @(negedge clock);

    // Write, then read it back. Every read result here is hand-written.
    do_op(0, 1, 9'h055, 32'hDEADBEEF, 1, 1, 32'h0, 0, 1);
    do_op(1, 0, 9'h055, 32'h0, 1, 1, 32'hDEADBEEF, 0, 1);
    // Read strobe held for 6 cycles gives exactly one response
    do_op(1, 0, 9'h055, 32'h0, 6, 1, 32'hDEADBEEF, 0, 1);

    do_op(0, 1, 9'h0A0, 32'h0BADF00D, 1, 1, 32'h0, 0, 1);
    do_op(0, 1, 9'h001, 32'h11111111, 1, 1, 32'h0, 0, 1);
    do_op(0, 1, 9'h1FF, 32'hA5A5A5A5, 1, 1, 32'h0, 0, 1);
    do_op(0, 1, 9'h010, 32'h12121212, 1, 1, 32'h0, 0, 1);
    do_op(1, 0, 9'h1FF, 32'h0, 1, 1, 32'hA5A5A5A5, 0, 1);
    do_op(1, 0, 9'h0A0, 32'h0, 1, 1, 32'h0BADF00D, 0, 1);
    do_op(1, 0, 9'h010, 32'h0, 1, 1, 32'h12121212, 0, 1);
    do_op(1, 0, 9'h001, 32'h0, 1, 1, 32'h11111111, 0, 1);

    // A write edge that arrives during WAIT is dropped
    @(negedge clock);
    Read    = 1'b1;
    Address = 9'h001;
    push_exp(1, 32'h11111111, 0, 1);
    @(negedge clock);
    Read   = 1'b0;
    Write  = 1'b1;
    DataIn = 32'h22222222;
    @(negedge clock);
    Write = 1'b0;
    drain();
    do_op(1, 0, 9'h001, 32'h0, 1, 1, 32'h11111111, 0, 1);

    // Read and Write edges in the same cycle
    do_op(1, 1, 9'h055, 32'h0, 1, 0, 32'h0, 0, 1);
    check("reqerror_set", {31'd0, ReqError}, 32'd1);
    repeat (5) @(negedge clock);
    check("reqerror_sticky", {31'd0, ReqError}, 32'd1);
    do_op(1, 0, 9'h055, 32'h0, 1, 1, 32'hDEADBEEF, 0, 1);
    check("reqerror_sticky_after_op", {31'd0, ReqError}, 32'd1);

    // Reset during WAIT aborts the write in flight
    @(negedge clock);
    Write   = 1'b1;
    Address = 9'h0A0;
    DataIn  = 32'h12345678;
    @(negedge clock);
    check("busy_inflight", {31'd0, Busy}, 32'd1);
    clear = 1'b0;
    #1;
    check("midreset_mdatain", Mdatain, 32'd0);
    check("midreset_memready", {31'd0, MemReady}, 32'd0);
    check("midreset_busy", {31'd0, Busy}, 32'd0);
    check("midreset_reqerror", {31'd0, ReqError}, 32'd0);
    check("midreset_wpfault", {31'd0, WpFault}, 32'd0);
    Write = 1'b0;
    repeat (2) @(negedge clock);
    clear      = 1'b1;
    last_rd    = 32'h0;
    last_known = 1'b1;
    do_op(1, 0, 9'h0A0, 32'h0, 1, 1, 32'h0BADF00D, 0, 1);

`ifdef MEM_WP_EN
    // Protected write: the sequence completes and WpFault pulses, but RAM is unchanged
    do_op(0, 1, 9'h00F, 32'hFFFFFFFF, 1, 1, 32'h0, 1, 1);
    do_op(1, 0, 9'h00F, 32'h0, 1, 1, 32'hFFFFFFFF, 0, 0);
`endif
    // The first address above the protected range is writable in both builds
    do_op(0, 1, 9'h010, 32'h34343434, 1, 1, 32'h0, 0, 1);
    do_op(1, 0, 9'h010, 32'h0, 1, 1, 32'h34343434, 0, 1);

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
